// File: rtl/uart_rx_word_packer.sv
// Packs WIDTH-bit UART symbols into words of 1..MAX_WORDS symbols with a
// one-word output holding register; symbols arriving while both slots are full are dropped.
module uart_rx_word_packer #(
  parameter  int WIDTH     = 8,
  parameter  int MAX_WORDS = 4,
  parameter  int MSB_FIRST = 1,
  localparam int CW        = $clog2(MAX_WORDS + 1),
  localparam int DW        = MAX_WORDS * WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic [CW-1:0]    len_i,
  input  logic             flush_i,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DW-1:0]    out_data,
  output logic [CW-1:0]    out_count,
  output logic             overflow
);

  logic [DW-1:0] asm_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] len_q;
  logic          pending_q;
  logic [DW-1:0] out_data_q;
  logic [CW-1:0] out_count_q;
  logic          out_valid_q;
  logic          overflow_q;

  logic          out_free;
  logic          xfer_pend;
  logic          hold;
  logic          accept;
  logic          first;
  logic [CW-1:0] cur_cnt;
  logic [CW-1:0] len_eff;
  logic [CW-1:0] cnt_w;
  logic [DW-1:0] asm_w;
  logic [DW-1:0] word_c;
  logic          close;
  logic          load_new;
  int            lane;

  function automatic logic [CW-1:0] clamp_len(input logic [CW-1:0] l);
    if (l == '0 || int'(l) > MAX_WORDS) return CW'(MAX_WORDS);
    return l;
  endfunction

  // A short MSB-first word sits in the top lanes of its nominal length; shift it down.
  function automatic logic [DW-1:0] realign(input logic [DW-1:0] w,
                                            input logic [CW-1:0] len,
                                            input logic [CW-1:0] c);
    logic [DW-1:0] r;
    int            sh;
    r  = '0;
    sh = (MSB_FIRST != 0) ? int'(len) - int'(c) : 0;
    for (int j = 0; j < MAX_WORDS; j++) begin
      if (j < int'(c) && (j + sh) < MAX_WORDS) r[j*WIDTH +: WIDTH] = w[(j+sh)*WIDTH +: WIDTH];
    end
    return r;
  endfunction

  always_comb begin
    out_free  = !out_valid_q || out_ready;
    xfer_pend = pending_q && out_free;
    hold      = pending_q && !out_free;
    accept    = in_valid && !hold;
    cur_cnt   = xfer_pend ? '0 : cnt_q;
    first     = (cur_cnt == '0);
    len_eff   = (accept && first) ? clamp_len(len_i) : len_q;
    lane      = (MSB_FIRST != 0) ? int'(len_eff) - 1 - int'(cur_cnt) : int'(cur_cnt);
    asm_w     = asm_q;
    cnt_w     = cur_cnt;
    if (accept) begin
      if (first) asm_w = '0;
      asm_w[lane*WIDTH +: WIDTH] = in_data;
      cnt_w = cur_cnt + 1'b1;
    end
    close    = !hold && (cnt_w != '0) && ((cnt_w == len_eff) || flush_i);
    word_c   = realign(asm_w, len_eff, cnt_w);
    load_new = close && out_free && !xfer_pend;
  end

  always_ff @(posedge clk) begin
    asm_q <= close ? word_c : asm_w;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q       <= '0;
      len_q       <= CW'(MAX_WORDS);
      pending_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_count_q <= '0;
      out_data_q  <= '0;
      overflow_q  <= 1'b0;
    end else begin
      overflow_q <= in_valid && hold;
      if (accept && first) len_q <= len_eff;
      cnt_q     <= load_new ? '0 : cnt_w;
      pending_q <= hold || (close && !load_new);
      if (xfer_pend) begin
        out_data_q  <= asm_q;
        out_count_q <= cnt_q;
        out_valid_q <= 1'b1;
      end else if (load_new) begin
        out_data_q  <= word_c;
        out_count_q <= cnt_w;
        out_valid_q <= 1'b1;
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_count = out_count_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_uart_rx_word_packer.sv
// Bench for uart_rx_word_packer: MSB-first and LSB-first instances share stimulus
// and are compared every cycle against a symbol-queue model, plus literal word checks.
module tb_uart_rx_word_packer;
  localparam int W  = 8;
  localparam int MW = 4;
  localparam int CW = $clog2(MW + 1);
  localparam int DW = MW * W;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic [W-1:0]  in_data = '0;
  logic [CW-1:0] len_i = CW'(4);
  logic          flush_i = 1'b0;
  logic          out_ready = 1'b1;

  logic          a_valid, b_valid, a_ovf, b_ovf;
  logic [DW-1:0] a_data, b_data;
  logic [CW-1:0] a_count, b_count;

  int checks = 0;
  int errors = 0;

  uart_rx_word_packer #(.WIDTH(W), .MAX_WORDS(MW), .MSB_FIRST(1)) u_msb (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .len_i(len_i),
    .flush_i(flush_i), .out_valid(a_valid), .out_ready(out_ready), .out_data(a_data),
    .out_count(a_count), .overflow(a_ovf));

  uart_rx_word_packer #(.WIDTH(W), .MAX_WORDS(MW), .MSB_FIRST(0)) u_lsb (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .len_i(len_i),
    .flush_i(flush_i), .out_valid(b_valid), .out_ready(out_ready), .out_data(b_data),
    .out_count(b_count), .overflow(b_ovf));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: a word is just the list of symbols it holds.
  logic [W-1:0] cur[$];
  logic [W-1:0] pend[$];
  logic [W-1:0] outw[$];
  bit m_pend, m_ov, m_ovf, m_clean;
  int mlen;

  function automatic logic [DW-1:0] build(input logic [W-1:0] q[$], input bit msb);
    logic [DW-1:0] r;
    int L;
    r = '0;
    L = q.size();
    for (int k = 0; k < L; k++) r[(msb ? (L-1-k) : k)*W +: W] = q[k];
    return r;
  endfunction

  function automatic int clampf(input int l);
    return (l == 0 || l > MW) ? MW : l;
  endfunction

  // Consumed-word log taken from the DUT outputs.
  logic [DW-1:0] log_a[$];
  logic [DW-1:0] log_b[$];
  int            log_c[$];
  int            ovf_seen = 0;

  bit            p_valid = 1'b0;
  logic [DW-1:0] p_a, p_b;
  logic [CW-1:0] p_c;

  initial begin
    bit free, xfer, hold;
    forever begin
      @(posedge clk);
      #1;
      if (!rst && p_valid && out_ready) begin
        log_a.push_back(p_a);
        log_b.push_back(p_b);
        log_c.push_back(int'(p_c));
      end
      if (a_ovf) ovf_seen++;
      if (rst) begin
        cur.delete(); pend.delete(); outw.delete();
        m_pend = 0; m_ov = 0; m_ovf = 0; m_clean = 1; mlen = MW;
      end else begin
        free  = !m_ov || out_ready;
        xfer  = m_pend && free;
        hold  = m_pend && !free;
        m_ovf = in_valid && hold;
        if (m_ov && out_ready) m_ov = 0;
        if (xfer) begin
          outw = pend; m_ov = 1; m_pend = 0; m_clean = 0;
        end
        if (in_valid && !hold) begin
          if (cur.size() == 0) mlen = clampf(int'(len_i));
          cur.push_back(in_data);
        end
        if (!hold && cur.size() > 0 && (cur.size() == mlen || flush_i)) begin
          if (free && !xfer) begin
            outw = cur; m_ov = 1; m_clean = 0;
          end else begin
            pend = cur; m_pend = 1;
          end
          cur.delete();
        end
      end
      chk("valid_msb", 32'(a_valid), 32'(m_ov));
      chk("valid_lsb", 32'(b_valid), 32'(m_ov));
      chk("ovf_msb", 32'(a_ovf), 32'(m_ovf));
      chk("ovf_lsb", 32'(b_ovf), 32'(m_ovf));
      if (m_ov || m_clean) begin
        chk("data_msb", a_data, m_clean ? '0 : build(outw, 1'b1));
        chk("data_lsb", b_data, m_clean ? '0 : build(outw, 1'b0));
        chk("count_msb", 32'(a_count), m_clean ? 0 : outw.size());
        chk("count_lsb", 32'(b_count), m_clean ? 0 : outw.size());
      end
      p_valid = a_valid; p_a = a_data; p_b = b_data; p_c = a_count;
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic sym(input logic [W-1:0] d);
    in_valid = 1'b1;
    in_data  = d;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic clear_log();
    log_a.delete(); log_b.delete(); log_c.delete(); ovf_seen = 0;
  endtask

  initial begin
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    idle(1);
    chk("reset_data", a_data, 32'h0);

    // Full word, both byte orders
    clear_log(); len_i = 4; out_ready = 1;
    sym(8'h11); sym(8'h22); sym(8'h33); sym(8'h44); idle(3);
    chk("w4_n", log_a.size(), 1);
    if (log_a.size() == 1) begin
      chk("w4_msb", log_a[0], 32'h11223344);
      chk("w4_lsb", log_b[0], 32'h44332211);
      chk("w4_cnt", log_c[0], 4);
    end

    // Two-symbol words
    clear_log(); len_i = 2;
    sym(8'hAA); sym(8'hBB); sym(8'hCC); sym(8'hDD); idle(3);
    chk("w2_n", log_a.size(), 2);
    if (log_a.size() == 2) begin
      chk("w2_a", log_a[0], 32'h0000AABB);
      chk("w2_b", log_a[1], 32'h0000CCDD);
      chk("w2_cnt", log_c[1], 2);
    end
    chk("w2_ovf", ovf_seen, 0);

    // Stall: one word held, one pending, ninth symbol dropped
    clear_log(); len_i = 4; out_ready = 0;
    for (int i = 1; i <= 9; i++) sym(W'(i));
    idle(2);
    chk("stall_ovf", ovf_seen, 1);
    chk("stall_n0", log_a.size(), 0);
    out_ready = 1; idle(4);
    chk("stall_n", log_a.size(), 2);
    if (log_a.size() == 2) begin
      chk("stall_a", log_a[0], 32'h01020304);
      chk("stall_b", log_a[1], 32'h05060708);
    end

    // Flush of a partial word, then a normal word
    clear_log();
    sym(8'h01); sym(8'h02); sym(8'h03);
    flush_i = 1; @(negedge clk); flush_i = 0;
    sym(8'h11); sym(8'h22); sym(8'h33); sym(8'h44); idle(3);
    chk("flush_n", log_a.size(), 2);
    if (log_a.size() == 2) begin
      chk("flush_msb", log_a[0], 32'h00010203);
      chk("flush_lsb", log_b[0], 32'h00030201);
      chk("flush_cnt", log_c[0], 3);
      chk("after_flush", log_a[1], 32'h11223344);
    end

    // Reset mid-word discards it
    clear_log();
    sym(8'h01); sym(8'h02);
    rst = 1; @(negedge clk); rst = 0;
    idle(2);
    chk("rst_valid", 32'(a_valid), 0);
    sym(8'hA1); sym(8'hA2); sym(8'hA3); sym(8'hA4); idle(3);
    chk("rst_n", log_a.size(), 1);
    if (log_a.size() == 1) chk("rst_word", log_a[0], 32'hA1A2A3A4);

    // Randomised traffic, all checking done by the model compare
    for (int c = 0; c < 4000; c++) begin
      in_valid  = ($urandom_range(0, 2) == 0);
      in_data   = W'($urandom);
      len_i     = CW'($urandom_range(0, 7));
      flush_i   = ($urandom_range(0, 15) == 0);
      out_ready = ($urandom_range(0, 9) < 6);
      rst       = ($urandom_range(0, 499) == 0);
      @(negedge clk);
    end
    in_valid = 0; flush_i = 0; rst = 0; out_ready = 1;
    idle(5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_rx_word_packer.md
# uart_rx_word_packer

Byte-to-word packer placed after the UART receiver. It collects `WIDTH`-bit symbols into words of 1..`MAX_WORDS` symbols, with a runtime-selectable length and a compile-time byte order. Completed words are presented on a valid/ready output backed by a one-word holding register, so assembly can continue while downstream stalls. A flush input emits partial words. Symbols that cannot be stored are dropped and flagged, because the UART line cannot be back-pressured.

## Interface
- `WIDTH`, 8, bits per received symbol.
- `MAX_WORDS`, 4, maximum symbols per output word; must be ≥ 1.
- `MSB_FIRST`, 1, 1: the first received symbol goes to the most significant occupied lane; 0: the first symbol goes to lane 0.
- `clk`  in  1  single clock; all logic on its rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `in_valid`  in  1  one-cycle strobe; `in_data` is a received symbol.
- `in_data`  in  `WIDTH`  received symbol.
- `len_i`  in  CW = $clog2(`MAX_WORDS`+1)  symbols per word. Sampled with the first symbol of each word. Values 0 and >`MAX_WORDS` mean `MAX_WORDS`.
- `flush_i`  in  1  close the current partial word.
- `out_valid`  out  1  holding register contains a word.
- `out_ready`  in  1  downstream accepts the word.
- `out_data`  out  `MAX_WORDS`*`WIDTH`  packed word. Right-aligned; unused upper lanes are zero.
- `out_count`  out  CW  number of valid symbols in `out_data`.
- `overflow`  out  1  one-cycle pulse when a symbol is dropped.

## Operation
- Storage:
  - Assembly register: `MAX_WORDS` lanes.
  - Fill counter `cnt`: 0..`MAX_WORDS`.
  - Latched length `len_q`.
  - `pending` flag: assembly holds a closed word.
  - Output holding register, which drives `out_data`, `out_count` and `out_valid`.
- Lane placement for symbol index k (0-based) in a word of length L:
  - `MSB_FIRST`=1: lane L-1-k.
  - `MSB_FIRST`=0: lane k.
  - Lane j occupies bits [j*WIDTH +: WIDTH].
- Accept: when `in_valid` is high and `pending`=0:
  - write the symbol into its lane;
  - increment `cnt`;
  - if `cnt` was 0, latch `len_q` from `len_i` (after clamping) and clear all lanes except the one being written.
- Close: the word is closed when `cnt` reaches `len_q`. It is also closed when `flush_i` is high and `cnt` ≥ 1.
  - On flush, a partial word of C symbols is re-aligned as if L = C: lanes C-1..0 are valid and upper lanes are zero.
  - When `flush_i` and `in_valid` occur in the same cycle, the symbol is included first, then the word is flushed.
  - `flush_i` with `cnt`=0 has no effect.
- Transfer: the output register is free when `out_valid`=0, or when `out_valid`=1 and `out_ready`=1 in this cycle.
  - If the output register is free, a closed word moves into it at the same edge. `cnt` resets to 0 and `pending` stays 0.
  - Otherwise `pending` is set and the assembly holds the word.
  - A pending word transfers at the first edge where the output register is free.
- Drop: `in_valid` while `pending`=1 and no transfer in that cycle discards the symbol and pulses `overflow`.
  - If the pending word transfers in that same cycle, the symbol is accepted as index 0 of the next word.
- Output handshake:
  - The word is consumed at an edge where `out_valid` and `out_ready` are both high.
  - `out_data`/`out_count` stay stable while `out_valid`=1 and `out_ready`=0.
  - `out_valid` deasserts after consumption unless a new word loads at that same edge.

## Timing
- Reset: `out_valid`=0, `out_data`=0, `out_count`=0, `overflow`=0. `cnt`=0, `pending`=0, `len_q`=`MAX_WORDS`.
- `rst` asserted mid-word discards the partial word and any pending word with no output.
- Latency from the final symbol (or `flush_i`) to `out_valid`: 1 cycle when the output register is free.
- Back-to-back words with `out_ready` held at 1 sustain one word per `len_q` input strobes, with no bubbles.
- With `out_ready`=0: one word is held in the output register and one closed word in the assembly. The next `in_valid` overflows.
- `overflow` is registered and goes high the cycle after the dropped strobe.
- `len_i` changes mid-word are ignored until `cnt` returns to 0.

## Test plan
- `len_i`=4, `out_ready`=1, symbols 11,22,33,44 → `out_valid` one cycle after 44 for one cycle; `out_data`=0x11223344, `out_count`=4.
- `len_i`=2, symbols AA,BB,CC,DD, `out_ready`=1 → two words 0x0000AABB then 0x0000CCDD, each with `out_count`=2; no `overflow`.
- `out_ready`=0, `len_i`=4, 9 symbols 01..09 → word 1 goes to the output register and word 2 becomes pending; symbol 09 pulses `overflow` once. Then `out_ready`=1 → 0x01020304 then 0x05060708 on consecutive cycles.
- Symbols 01,02,03, then `flush_i` → 0x00010203 with `out_count`=3; a following 4 symbols form a normal 4-symbol word.
- `MSB_FIRST`=0, `len_i`=4, symbols 11,22,33,44 → 0x44332211. Flush after 11,22 → 0x00002211.
- `rst` for one cycle after 2 of 4 symbols, then 4 new symbols → only the new word appears; all outputs are 0 during and after `rst` until completion.
